// File: rtl/prog_load_ctrl.sv
// Program loader / CPU sequencer: streams UART bytes into program memory while
// Load is high, then releases the CPU through a timed reset window and runs it.
module prog_load_ctrl #(
    parameter int DEPTH      = 32,
    parameter int RST_CYCLES = 2,
    localparam int AW        = $clog2(DEPTH),
    localparam int RW        = $clog2(RST_CYCLES + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Load,
    input  logic [7:0]    Rx_data,
    input  logic          Rx_valid,
    input  logic          Rx_fe,
    input  logic          Cpu_halt,
    output logic          Mem_we,
    output logic [AW-1:0] Mem_addr,
    output logic [7:0]    Mem_wdata,
    output logic          Cpu_rst,
    output logic          Cpu_run,
    output logic [AW:0]   Byte_count,
    output logic          Load_err,
    output logic          Busy
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RSTW, S_RUN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [RW-1:0]   r_rcnt;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [7:0]      r_mem_wdata;
    logic            r_cpu_rst;
    logic            r_cpu_run;
    logic [AW:0]     r_count;
    logic            r_err;
    logic            r_busy;

    logic            w_full;
    logic            w_good;
    logic            w_bad;
    logic            w_enter_load;
    logic            w_enter_rstw;

    assign w_full       = (r_count == (AW+1)'(DEPTH));
    assign w_good       = (r_state == S_LOAD) && Rx_valid && !Rx_fe && !w_full;
    assign w_bad        = (r_state == S_LOAD) && Rx_valid && (Rx_fe || w_full);
    assign w_enter_load = (w_next == S_LOAD) && (r_state != S_LOAD);
    assign w_enter_rstw = (w_next == S_RSTW) && (r_state != S_RSTW);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (Load) w_next = S_LOAD;
            S_LOAD: if (!Load) w_next = S_RSTW;
            S_RSTW: begin
                if (Load)
                    w_next = S_LOAD;
                else if (r_rcnt == '0)
                    // an empty load never lets the CPU out of reset
                    w_next = (r_count == '0) ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (Load)
                    w_next = S_LOAD;
                else if (Cpu_halt)
                    w_next = S_DONE;
            end
            S_DONE: if (Load) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_rcnt      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rst   <= 1'b1;
            r_cpu_run   <= 1'b0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_mem_we <= w_good;
            // the write pointer is the byte count; it stops at DEPTH, never wraps
            if (w_good) begin
                r_mem_addr  <= r_count[AW-1:0];
                r_mem_wdata <= Rx_data;
                r_count     <= r_count + 1'b1;
            end
            if (w_bad)
                r_err <= 1'b1;
            if (w_enter_load) begin
                r_mem_addr <= '0;
                r_count    <= '0;
                r_err      <= 1'b0;
            end
            if (w_enter_rstw)
                r_rcnt <= RW'(RST_CYCLES - 1);
            else if (r_state == S_RSTW)
                r_rcnt <= r_rcnt - 1'b1;
            r_cpu_rst <= (w_next == S_IDLE) || (w_next == S_LOAD) || (w_next == S_RSTW);
            r_cpu_run <= (w_next == S_RUN);
            r_busy    <= (w_next == S_LOAD) || (w_next == S_RSTW);
        end
    end

    assign Mem_we     = r_mem_we;
    assign Mem_addr   = r_mem_addr;
    assign Mem_wdata  = r_mem_wdata;
    assign Cpu_rst    = r_cpu_rst;
    assign Cpu_run    = r_cpu_run;
    assign Byte_count = r_count;
    assign Load_err   = r_err;
    assign Busy       = r_busy;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl: a per-cycle vector table for the basic
// load/run flow plus hand-written sequences for errors, overflow and reset.
module tb_prog_load_ctrl;

    logic       Clk = 1'b0;
    logic       Reset, Load, Rx_valid, Rx_fe, Cpu_halt;
    logic [7:0] Rx_data;
    logic       Mem_we, Cpu_rst, Cpu_run, Load_err, Busy;
    logic [4:0] Mem_addr;
    logic [7:0] Mem_wdata;
    logic [5:0] Byte_count;

    int n_checks = 0;
    int n_err    = 0;

    prog_load_ctrl #(.DEPTH(32), .RST_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .Load(Load), .Rx_data(Rx_data),
        .Rx_valid(Rx_valid), .Rx_fe(Rx_fe), .Cpu_halt(Cpu_halt),
        .Mem_we(Mem_we), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata),
        .Cpu_rst(Cpu_rst), .Cpu_run(Cpu_run), .Byte_count(Byte_count),
        .Load_err(Load_err), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       ld, rv, fe;
        logic [7:0] d;
        logic       h;
        logic       we;
        logic [4:0] addr;
        logic [7:0] wd;
        logic       rst, run;
        logic [5:0] cnt;
        logic       err, busy;
    } vec_t;

    vec_t       tbl[11];
    logic [7:0] prog[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string t, input logic we, input logic [4:0] addr,
                           input logic [7:0] wd, input logic rst, input logic run,
                           input logic [5:0] cnt, input logic err, input logic busy);
        chk({t, ".we"},   32'(Mem_we),     32'(we));
        chk({t, ".addr"}, 32'(Mem_addr),   32'(addr));
        chk({t, ".wd"},   32'(Mem_wdata),  32'(wd));
        chk({t, ".rst"},  32'(Cpu_rst),    32'(rst));
        chk({t, ".run"},  32'(Cpu_run),    32'(run));
        chk({t, ".cnt"},  32'(Byte_count), 32'(cnt));
        chk({t, ".err"},  32'(Load_err),   32'(err));
        chk({t, ".busy"}, 32'(Busy),       32'(busy));
    endtask

    task automatic apply(input logic ld, input logic rv, input logic fe,
                         input logic [7:0] d, input logic h);
        Load = ld; Rx_valid = rv; Rx_fe = fe; Rx_data = d; Cpu_halt = h;
        @(posedge Clk);
        #1;
    endtask

    // Stream six bytes in LOAD; byte at index fe_idx carries a frame error.
    task automatic load_seq(input string t, input logic [7:0] b[6], input int fe_idx);
        int ptr = 0;
        logic [7:0] lastwd = 8'h00;
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b1, (i == fe_idx), b[i], 1'b0);
            if (i == fe_idx) begin
                chk_all($sformatf("%s.fe%0d", t, i), 1'b0, 5'(ptr - 1), lastwd,
                        1'b1, 1'b0, 6'(ptr), 1'b1, 1'b1);
            end else begin
                chk_all($sformatf("%s.b%0d", t, i), 1'b1, 5'(ptr), b[i],
                        1'b1, 1'b0, 6'(ptr + 1), (fe_idx >= 0 && i > fe_idx), 1'b1);
                ptr++;
                lastwd = b[i];
            end
        end
    endtask

    // Load falls: two cycles of CPU reset, then the CPU runs.
    task automatic release_check(input string t, input logic [5:0] cnt, input logic err);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk({t, ".w1rst"}, 32'(Cpu_rst), 32'd1);
        chk({t, ".w1run"}, 32'(Cpu_run), 32'd0);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk({t, ".w2rst"}, 32'(Cpu_rst), 32'd1);
        chk({t, ".w2busy"}, 32'(Busy), 32'd1);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk({t, ".runrst"}, 32'(Cpu_rst), 32'd0);
        chk({t, ".run"},    32'(Cpu_run), 32'd1);
        chk({t, ".busy"},   32'(Busy),    32'd0);
        chk({t, ".cnt"},    32'(Byte_count), 32'(cnt));
        chk({t, ".err"},    32'(Load_err),   32'(err));
    endtask

    initial begin
        int bad_run;
        prog = '{8'hC0, 8'h40, 8'hA3, 8'hE5, 8'hA0, 8'h00};
        //            ld    rv    fe    d      h     we    addr  wd     rst   run   cnt   err   busy
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'hC0, 1'b0, 1'b1, 5'd0, 8'hC0, 1'b1, 1'b0, 6'd1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h40, 1'b0, 1'b1, 5'd1, 8'h40, 1'b1, 1'b0, 6'd2, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'hA3, 1'b0, 1'b1, 5'd2, 8'hA3, 1'b1, 1'b0, 6'd3, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'hE5, 1'b0, 1'b1, 5'd3, 8'hE5, 1'b1, 1'b0, 6'd4, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'hA0, 1'b0, 1'b1, 5'd4, 8'hA0, 1'b1, 1'b0, 6'd5, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd5, 8'h00, 1'b1, 1'b0, 6'd6, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd5, 8'h00, 1'b1, 1'b0, 6'd6, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd5, 8'h00, 1'b1, 1'b0, 6'd6, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd5, 8'h00, 1'b0, 1'b1, 6'd6, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd5, 8'h00, 1'b0, 1'b1, 6'd6, 1'b0, 1'b0};

        Reset = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk_all("reset", 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        Reset = 1'b0;

        // Basic load and run
        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].ld, tbl[i].rv, tbl[i].fe, tbl[i].d, tbl[i].h);
            chk_all($sformatf("basic[%0d]", i), tbl[i].we, tbl[i].addr, tbl[i].wd,
                    tbl[i].rst, tbl[i].run, tbl[i].cnt, tbl[i].err, tbl[i].busy);
        end

        // Halt into DONE, then reload
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk_all("done", 1'b0, 5'd5, 8'h00, 1'b0, 1'b0, 6'd6, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk_all("done.hold", 1'b0, 5'd5, 8'h00, 1'b0, 1'b0, 6'd6, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk_all("reload.entry", 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
        load_seq("reload", prog, -1);
        release_check("reload.rel", 6'd6, 1'b0);

        // Frame error on the third byte, aborting the run with Load
        apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk_all("fe.entry", 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
        load_seq("fe", prog, 2);
        release_check("fe.rel", 6'd5, 1'b1);

        // Overflow: 34 bytes into 32 locations
        apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk_all("ovf.entry", 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
        for (int i = 0; i < 34; i++) begin
            apply(1'b1, 1'b1, 1'b0, 8'(i), 1'b0);
            if (i < 32)
                chk_all($sformatf("ovf.w%0d", i), 1'b1, 5'(i), 8'(i), 1'b1, 1'b0,
                        6'(i + 1), 1'b0, 1'b1);
            else
                chk_all($sformatf("ovf.drop%0d", i), 1'b0, 5'd31, 8'h1F, 1'b1, 1'b0,
                        6'd32, 1'b1, 1'b1);
        end
        release_check("ovf.rel", 6'd32, 1'b1);

        // Empty load: 50 cycles with no bytes, CPU must never run
        bad_run = 0;
        for (int i = 0; i < 50; i++) begin
            apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            if (Cpu_run !== 1'b0 || Cpu_rst !== 1'b1) bad_run++;
        end
        chk("empty.cnt", 32'(Byte_count), 32'd0);
        chk("empty.err", 32'(Load_err), 32'd0);
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            chk($sformatf("empty.rstw%0d.busy", i), 32'(Busy), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            if (Cpu_run !== 1'b0 || Cpu_rst !== 1'b1) bad_run++;
        end
        chk("empty.idle.busy", 32'(Busy), 32'd0);
        chk("empty.norun", 32'(bad_run), 32'd0);

        // Byte arriving on the same cycle Load falls is still written
        apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 8'h11, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 8'h22, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 8'h33, 1'b0);
        chk_all("edge.fall", 1'b1, 5'd2, 8'h33, 1'b1, 1'b0, 6'd3, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk_all("edge.rstw", 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 6'd3, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk_all("edge.run", 1'b0, 5'd2, 8'h33, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0);

        // Reset mid-load, three cycles after a strobe
        apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 8'h44, 1'b0);
        chk_all("mid.w0", 1'b1, 5'd0, 8'h44, 1'b1, 1'b0, 6'd1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        Reset = 1'b1;
        apply(1'b1, 1'b1, 1'b0, 8'h55, 1'b0);
        chk_all("mid.reset", 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            chk_all($sformatf("mid.after%0d", i), 1'b0, 5'd0, 8'h00, 1'b1, 1'b0,
                    6'd0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
